// File: rtl/rv32i_types.sv
// Shared RV32 type definitions used by the EX-stage mul/div unit.
// Holds the RV32M funct3 encoding and the OP funct7 value that marks M-extension ops.
package rv32i_types;

  localparam logic [6:0] funct7_muldiv = 7'b0000001;

  typedef enum logic [2:0] {
    mul    = 3'd0,
    mulh   = 3'd1,
    mulhsu = 3'd2,
    mulhu  = 3'd3,
    div    = 3'd4,
    divu   = 3'd5,
    rem    = 3'd6,
    remu   = 3'd7
  } mul_funct3_t;

  // Upper half of the funct3 space is the divide family.
  function automatic logic is_div_op(input mul_funct3_t f);
    return f[2];
  endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// EX-stage handshake between the ID/EX register and the mul/div unit.
// The pipeline drives the master side; the unit sits on the slave side.
interface ex_muldiv_unit_if #(parameter int XLEN = 32);
  import rv32i_types::*;

  logic            valid_ex;
  logic            is_muldiv_ex;
  mul_funct3_t     funct3_ex;
  logic [XLEN-1:0] rs1_ex;
  logic [XLEN-1:0] rs2_ex;
  logic            flush;
  logic            hold;
  logic            stall_req;
  logic            result_valid;
  logic [XLEN-1:0] result;

  modport master (
    output valid_ex, is_muldiv_ex, funct3_ex, rs1_ex, rs2_ex, flush, hold,
    input  stall_req, result_valid, result
  );

  modport slave (
    input  valid_ex, is_muldiv_ex, funct3_ex, rs1_ex, rs2_ex, flush, hold,
    output stall_req, result_valid, result
  );

endinterface

// File: rtl/muldiv_iter_step.sv
// One radix-2 iteration of the mul/div datapath, purely combinational.
// Multiply: {product_hi, multiplier} shift-add. Divide: {remainder, quotient} restoring step.
module muldiv_iter_step #(
  parameter int XLEN = 32
) (
  input  logic              i_is_div,
  input  logic [2*XLEN-1:0] i_acc,
  input  logic [XLEN-1:0]   i_opnd,
  output logic [2*XLEN-1:0] o_acc
);

  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_top;
  logic [XLEN-1:0] w_diff;
  logic            w_ge;

  // Shifted partial remainder needs one extra bit before the compare.
  assign w_sum  = {1'b0, i_acc[2*XLEN-1:XLEN]} + (i_acc[0] ? {1'b0, i_opnd} : {(XLEN+1){1'b0}});
  assign w_top  = i_acc[2*XLEN-1:XLEN-1];
  assign w_ge   = w_top >= {1'b0, i_opnd};
  assign w_diff = w_top[XLEN-1:0] - i_opnd;

  always_comb begin
    if (i_is_div) begin
      o_acc = w_ge ? {w_diff, i_acc[XLEN-2:0], 1'b1} : {i_acc[2*XLEN-2:0], 1'b0};
    end else begin
      o_acc = {w_sum, i_acc[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage: 32 radix-2 iterations per op,
// with divide-by-zero and signed-overflow short-cuts straight to DONE.
module ex_muldiv_unit
  import rv32i_types::*;
#(
  parameter int XLEN       = 32,
  parameter int ITER_CNT_W = 6
) (
  input logic             clk,
  input logic             rst_n,
  ex_muldiv_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                r_state, w_next_state;
  logic [ITER_CNT_W-1:0] r_cnt;
  logic [2*XLEN-1:0]     r_acc, w_acc_next, w_prod;
  logic [XLEN-1:0]       r_opnd, r_result;
  mul_funct3_t           r_funct3;
  logic                  r_neg_res, r_neg_rem;

  logic                  w_start, w_is_div, w_special, w_div_zero, w_div_ovf, w_last, w_stall;
  logic                  w_a_signed, w_b_signed, w_a_neg, w_b_neg;
  logic [XLEN-1:0]       w_abs_a, w_abs_b, w_special_res, w_quot, w_rem, w_final;

  assign w_start    = (r_state == IDLE) & bus.valid_ex & bus.is_muldiv_ex & ~bus.flush;
  assign w_is_div   = is_div_op(bus.funct3_ex);
  assign w_div_zero = w_is_div & (bus.rs2_ex == '0);
  assign w_div_ovf  = w_is_div & ~bus.funct3_ex[0] & (bus.rs1_ex == {1'b1, {(XLEN-1){1'b0}}})
                    & (bus.rs2_ex == '1);
  assign w_special  = w_div_zero | w_div_ovf;
  assign w_last     = r_cnt == ITER_CNT_W'(XLEN-1);

  // Overflow quotient equals rs1 (the most negative value), so both special cases share a mux.
  assign w_special_res = bus.funct3_ex[1] ? (w_div_zero ? bus.rs1_ex : '0)
                                          : (w_div_zero ? '1 : bus.rs1_ex);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    w_a_signed = 1'b0;
    w_b_signed = 1'b0;
    case (bus.funct3_ex)
      mulh, div, rem: begin
        w_a_signed = 1'b1;
        w_b_signed = 1'b1;
      end
      mulhsu:  w_a_signed = 1'b1;
      default: ;
    endcase
  end

  assign w_a_neg = w_a_signed & bus.rs1_ex[XLEN-1];
  assign w_b_neg = w_b_signed & bus.rs2_ex[XLEN-1];
  assign w_abs_a = w_a_neg ? -bus.rs1_ex : bus.rs1_ex;
  assign w_abs_b = w_b_neg ? -bus.rs2_ex : bus.rs2_ex;

  muldiv_iter_step #(.XLEN(XLEN)) u_step (
    .i_is_div (is_div_op(r_funct3)),
    .i_acc    (r_acc),
    .i_opnd   (r_opnd),
    .o_acc    (w_acc_next)
  );

  always_comb begin
    w_prod = r_neg_res ? -w_acc_next : w_acc_next;
    w_quot = r_neg_res ? -w_acc_next[XLEN-1:0] : w_acc_next[XLEN-1:0];
    w_rem  = r_neg_rem ? -w_acc_next[2*XLEN-1:XLEN] : w_acc_next[2*XLEN-1:XLEN];
    case (r_funct3)
      mul:                 w_final = w_prod[XLEN-1:0];
      mulh, mulhsu, mulhu: w_final = w_prod[2*XLEN-1:XLEN];
      div, divu:           w_final = w_quot;
      default:             w_final = w_rem;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_stall      = 1'b0;
    case (r_state)
      IDLE: if (w_start) begin
        w_stall      = 1'b1;
        w_next_state = w_special ? DONE : BUSY;
      end
      BUSY: if (bus.flush) begin
        w_next_state = IDLE;
      end else begin
        w_stall = 1'b1;
        if (w_last) w_next_state = DONE;
      end
      DONE: if (bus.flush || !bus.hold) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_opnd    <= '0;
      r_funct3  <= mul;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_result  <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_start) begin
          r_cnt     <= '0;
          r_funct3  <= bus.funct3_ex;
          r_neg_res <= w_a_neg ^ w_b_neg;
          r_neg_rem <= w_a_neg;
          // Divide iterates on the dividend, multiply on the multiplier, both in the low half.
          r_acc     <= {{XLEN{1'b0}}, w_is_div ? w_abs_a : w_abs_b};
          r_opnd    <= w_is_div ? w_abs_b : w_abs_a;
          if (w_special) r_result <= w_special_res;
        end
        BUSY: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) r_result <= w_final;
        end
        default: ;
      endcase
    end
  end

  assign bus.stall_req    = w_stall;
  assign bus.result_valid = (r_state == DONE);
  assign bus.result       = r_result;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: reference model feeds a result scoreboard,
// plus latency, flush, hold and reset behaviour checks.
module tb_ex_muldiv_unit;
  import rv32i_types::*;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  logic [31:0] sb_q[$];

  ex_muldiv_unit_if #(.XLEN(32)) bus ();

  ex_muldiv_unit #(.XLEN(32), .ITER_CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h expected=%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, sp;
    logic [63:0] ua, ub, up;
    logic ovf;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ua  = {32'h0, a};
    ub  = {32'h0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin up = ua * ub; return up[31:0]; end
      3'd1: begin sp = sa * sb; return sp[63:32]; end
      3'd2: begin sp = sa * $signed(ub); return sp[63:32]; end
      3'd3: begin up = ua * ub; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        return $signed(a) / $signed(b);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    return 33;
  endfunction

  // Called just after a negedge; leaves the bench just after the negedge of the first IDLE cycle.
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input int hc);
    logic [31:0] exp;
    int n;
    exp = model(f3, a, b);
    sb_q.push_back(exp);
    bus.valid_ex     = 1'b1;
    bus.is_muldiv_ex = 1'b1;
    bus.funct3_ex    = mul_funct3_t'(f3);
    bus.rs1_ex       = a;
    bus.rs2_ex       = b;
    #1;
    n = 0;
    while (bus.stall_req && n < 100) begin
      n++;
      @(negedge clk); #1;
    end
    check("stall_cycles", 32'(n), 32'(exp_latency(f3, a, b)));
    check("done_stall", 32'(bus.stall_req), 32'd0);
    for (int k = 0; k <= hc; k++) begin
      check("done_valid", 32'(bus.result_valid), 32'd1);
      check("done_result", bus.result, exp);
      bus.hold = (k < hc);
      @(negedge clk); #1;
    end
    bus.valid_ex = 1'b0;
    bus.hold     = 1'b0;
    #1;
    check("idle_valid", 32'(bus.result_valid), 32'd0);
    check("idle_stall", 32'(bus.stall_req), 32'd0);
  endtask

  // Scoreboard: one pop per rising edge of result_valid.
  logic prev_valid = 1'b0;
  initial begin
    forever begin
      @(posedge clk); #2;
      if (bus.result_valid && !prev_valid) begin
        check("sb_expected", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) check("sb_result", bus.result, sb_q.pop_front());
      end
      prev_valid = bus.result_valid;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    logic [2:0]  f3;
    logic [31:0] a, b;
    rst_n            = 1'b0;
    bus.valid_ex     = 1'b0;
    bus.is_muldiv_ex = 1'b0;
    bus.funct3_ex    = mul;
    bus.rs1_ex       = '0;
    bus.rs2_ex       = '0;
    bus.flush        = 1'b0;
    bus.hold         = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_stall", 32'(bus.stall_req), 32'd0);
    check("rst_valid", 32'(bus.result_valid), 32'd0);
    check("rst_result", bus.result, 32'd0);
    rst_n = 1'b1;
    @(negedge clk); #1;

    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0);
    do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 0);
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0);
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0);
    do_op(3'd5, 32'd100, 32'd7, 0);
    do_op(3'd7, 32'd100, 32'd7, 0);
    do_op(3'd4, 32'd5, 32'd0, 0);
    do_op(3'd6, 32'd5, 32'd0, 0);
    do_op(3'd5, 32'd5, 32'd0, 0);
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);

    // Flush in BUSY cycle 10, then a normal MUL must still work.
    bus.valid_ex = 1'b1; bus.is_muldiv_ex = 1'b1; bus.funct3_ex = mul;
    bus.rs1_ex = 32'd5; bus.rs2_ex = 32'd6;
    repeat (10) @(negedge clk);
    bus.flush = 1'b1;
    #1 check("flush_stall_now", 32'(bus.stall_req), 32'd0);
    @(negedge clk); #1;
    bus.flush = 1'b0; bus.valid_ex = 1'b0;
    #1;
    check("flush_idle_stall", 32'(bus.stall_req), 32'd0);
    check("flush_no_valid", 32'(bus.result_valid), 32'd0);
    do_op(3'd0, 32'd3, 32'd4, 0);

    // Flush together with a would-be start: nothing launches.
    bus.valid_ex = 1'b1; bus.flush = 1'b1; bus.funct3_ex = div;
    bus.rs1_ex = 32'd9; bus.rs2_ex = 32'd0;
    #1 check("flush_start_stall", 32'(bus.stall_req), 32'd0);
    @(negedge clk); #1;
    bus.flush = 1'b0; bus.valid_ex = 1'b0;
    #1;
    check("flush_start_valid", 32'(bus.result_valid), 32'd0);
    check("flush_start_idle", 32'(bus.stall_req), 32'd0);

    do_op(3'd1, 32'h1234_5678, 32'hF0F0_0F0F, 3);
    do_op(3'd4, 32'hFFFF_FC00, 32'd24, 0);
    do_op(3'd0, 32'hDEAD_BEEF, 32'h0000_1001, 0);

    for (int i = 0; i < 16; i++) begin
      f3 = 3'($urandom_range(7));
      a  = $urandom;
      b  = $urandom;
      if (i % 4 == 1) b = 32'($urandom_range(9));
      if (i % 5 == 2) b = 32'hFFFF_FFFF;
      do_op(f3, a, b, int'($urandom_range(2)));
    end

    // Reset in the middle of BUSY aborts to reset values.
    bus.valid_ex = 1'b1; bus.funct3_ex = divu;
    bus.rs1_ex = 32'd1000; bus.rs2_ex = 32'd3;
    repeat (5) @(negedge clk);
    rst_n = 1'b0; bus.valid_ex = 1'b0;
    @(negedge clk); #1;
    check("rst_busy_stall", 32'(bus.stall_req), 32'd0);
    check("rst_busy_valid", 32'(bus.result_valid), 32'd0);
    check("rst_busy_result", bus.result, 32'd0);
    rst_n = 1'b1;
    @(negedge clk); #1;
    do_op(3'd7, 32'd1000, 32'd3, 0);

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the EX stage.
- Consumes the operands and control that the ID/EX pipeline register presents to EX, and produces a 32-bit result for the EX result mux.
- Raises a stall request that freezes the IF/ID and ID/EX registers while it computes.
- Runs one radix-2 iteration per cycle: 32 iterations for every op, with short-cuts for divide-by-zero and signed overflow.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- ITER_CNT_W, 6, width of the iteration counter; must hold the value XLEN.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- valid_ex  in  1  EX holds a real (non-bubble) instruction
- is_muldiv_ex  in  1  EX instruction is an OP-opcode instruction with funct7=0000001
- funct3_ex  in  3  RV32M op select (mul_funct3_t)
- rs1_ex  in  32  forwarded rs1 operand
- rs2_ex  in  32  forwarded rs2 operand
- flush  in  1  branch/jump redirect kills the EX instruction
- hold  in  1  downstream stall (memory) that prevents EX from retiring
- stall_req  out  1  freeze IF/ID and ID/EX; EX must not advance
- result_valid  out  1  result is valid this cycle for the EX instruction
- result  out  32  mul/div result

Behaviour:
- States: IDLE, BUSY, DONE.
- Reset (rst_n=0 at a clk edge): state=IDLE, counter=0, all datapath regs=0, result=0, result_valid=0. stall_req=0 once the reset is in effect.
- start = (state==IDLE) & valid_ex & is_muldiv_ex & ~flush.

IDLE:
- On start: latch operands and funct3.
- Compute signs per op:
  - MUL: unsigned magnitude path, low word.
  - MULH: signed x signed.
  - MULHSU: signed x unsigned.
  - MULHU: unsigned x unsigned.
  - DIV/REM: signed.
  - DIVU/REMU: unsigned.
- Take absolute values for signed operands and record the result sign. Go to BUSY with counter=0.
- Div special cases go directly to DONE, skipping BUSY:
  - rs2==0: quotient=32'hFFFF_FFFF, remainder=rs1.
  - Signed rs1=32'h8000_0000 with rs2=32'hFFFF_FFFF: quotient=32'h8000_0000, remainder=0.

BUSY:
- Multiply: shift-add into a 64-bit product accumulator.
- Divide: restoring shift-subtract over a 64-bit remainder/quotient register.
- counter increments each cycle. After iteration 32 (counter==31 at the edge), apply sign correction and go to DONE.
  - Product negated if the result sign is set.
  - Quotient sign = sign(rs1) XOR sign(rs2).
  - Remainder takes sign(rs1).
- Select output: MUL -> product[31:0]; MULH/MULHSU/MULHU -> product[63:32]; DIV/DIVU -> quotient; REM/REMU -> remainder.

DONE:
- result_valid=1 and result is held stable.
- hold=1: stay in DONE. hold=0: go to IDLE next edge.

stall_req (combinational) = start | (state==BUSY) | (state==IDLE special-case start).
- It is low in DONE, so ID/EX advances in the DONE cycle.
- Because start requires IDLE, the same instruction can never re-launch.

Latency:
- Normal op: start edge at cycle 0; BUSY cycles 1..32; DONE cycle 33. stall_req high in cycles 0..32.
- Special case: DONE in cycle 1; stall_req high in cycle 0 only.

flush:
- In BUSY or DONE: go to IDLE next edge, result_valid=0 next cycle, datapath regs keep garbage. stall_req drops in the same cycle flush is seen.
- flush and start in the same cycle: no start.

Other rules:
- valid_ex or is_muldiv_ex low while in BUSY is ignored; operands were latched at start.
- rst_n low mid-operation: abort to reset values on that edge.
- All arithmetic is modulo 2^32/2^64; no exceptions are raised.

Decomposition:
- rv32i_types gets typedef enum logic [2:0] mul_funct3_t: mul=0, mulh=1, mulhsu=2, mulhu=3, div=4, divu=5, rem=6, remu=7.
- rv32i_types gets localparam funct7_muldiv = 7'b0000001.
- The FSM state enum stays local to the module.
- One sub-module: muldiv_iter_step, purely combinational. It computes the next accumulator for one mul or div iteration, so it can be unit-tested separately.

Test Plan:
- MUL rs1=7, rs2=-3 (32'hFFFF_FFFD) -> stall_req high 33 cycles; DONE in cycle 33; result=32'hFFFF_FFEB.
- MULH rs1=32'h8000_0000, rs2=32'h8000_0000 -> 32'h4000_0000. MULHU 32'hFFFF_FFFF x 32'hFFFF_FFFF -> 32'hFFFF_FFFE. MULHSU -1 x 32'hFFFF_FFFF -> 32'hFFFF_FFFF.
- DIV -7/2 -> 32'hFFFF_FFFD; REM -7/2 -> 32'hFFFF_FFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIV x/0 with rs1=5 -> quotient 32'hFFFF_FFFF, REM gives 5, done in cycle 1. DIV 32'h8000_0000 / -1 -> 32'h8000_0000, REM gives 0.
- Flush at BUSY cycle 10 -> state IDLE next edge, stall_req low, no result_valid. A following MUL 3x4 then returns 12 normally.
- hold high for 3 cycles during DONE -> result_valid and result stable 4 cycles, no restart. Back-to-back DIV and MUL each complete with correct values. Reset asserted in BUSY -> all outputs 0 next cycle.
